// File: rtl/mvau_inp_buf_ctrl.sv
// Steps the MVAU input buffer through one write pass and NF-1 replay passes per vector.
// Latency: zero; every output is combinational from state plus in_v/out_rdy.
// Backpressure: out_rdy low freezes all state; in_rdy is held low while stalled or replaying.
module mvau_inp_buf_ctrl #(
    parameter int SF       = 4,
    parameter int NF       = 3,
    parameter int BUF_ADDR = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_v,
    output logic                in_rdy,
    input  logic                out_rdy,
    output logic                wr_en,
    output logic                rd_en,
    output logic [BUF_ADDR-1:0] addr,
    output logic                out_v,
    output logic                sf_first,
    output logic                sf_last,
    output logic                nf_last
);

    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [BUF_ADDR-1:0] SF_LAST = BUF_ADDR'(SF - 1);
    localparam logic [NFW-1:0]      NF_LAST = NFW'(NF - 1);

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } mode_e;

    mode_e               mode_q, mode_d;
    logic [BUF_ADDR-1:0] sf_cnt_q, sf_cnt_d;
    logic [NFW-1:0]      nf_cnt_q, nf_cnt_d;
    logic                beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= WRITE;
            sf_cnt_q <= '0;
            nf_cnt_q <= '0;
        end else begin
            mode_q   <= mode_d;
            sf_cnt_q <= sf_cnt_d;
            nf_cnt_q <= nf_cnt_d;
        end
    end

    always_comb begin
        in_rdy   = 1'b0;
        out_v    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        addr     = '0;
        sf_first = 1'b0;
        sf_last  = 1'b0;
        nf_last  = 1'b0;
        beat     = 1'b0;
        mode_d   = mode_q;
        sf_cnt_d = sf_cnt_q;
        nf_cnt_d = nf_cnt_q;

        // While in reset every output is held at zero, independent of the stored state.
        if (!rst) begin
            case (mode_q)
                WRITE: begin
                    in_rdy = out_rdy;
                    out_v  = in_v;
                end
                READ: begin
                    out_v = 1'b1;
                    rd_en = 1'b1;
                end
                default: ;
            endcase

            beat     = out_v & out_rdy;
            wr_en    = beat & (mode_q == WRITE);
            addr     = sf_cnt_q;
            sf_first = out_v & (sf_cnt_q == '0);
            sf_last  = out_v & (sf_cnt_q == SF_LAST);
            nf_last  = (nf_cnt_q == NF_LAST);

            if (beat) begin
                if (sf_cnt_q != SF_LAST) begin
                    sf_cnt_d = sf_cnt_q + 1'b1;
                end else begin
                    sf_cnt_d = '0;
                    if (nf_cnt_q != NF_LAST) begin
                        nf_cnt_d = nf_cnt_q + 1'b1;
                        mode_d   = READ;
                    end else begin
                        nf_cnt_d = '0;
                        mode_d   = WRITE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Bench for mvau_inp_buf_ctrl: three parameterisations (4x3, 4x1, 1x2), expected beats queued
// by the stimulus and popped by per-instance monitors on every handshake.
module tb_mvau_inp_buf_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Beat record: {wr_en, rd_en, sf_first, sf_last, nf_last, addr[1:0]}; in_rdy must equal wr_en on a beat.
    localparam logic [6:0] V43 [12] = '{
        7'b1010000, 7'b1000001, 7'b1000010, 7'b1001011,
        7'b0110000, 7'b0100001, 7'b0100010, 7'b0101011,
        7'b0110100, 7'b0100101, 7'b0100110, 7'b0101111
    };
    localparam logic [6:0] V41 [4] = '{7'b1010100, 7'b1000101, 7'b1000110, 7'b1001111};
    localparam logic [6:0] V12 [2] = '{7'b1011000, 7'b0111100};

    logic rst0, in_v0, in_rdy0, out_rdy0, wr_en0, rd_en0, out_v0, sf_first0, sf_last0, nf_last0;
    logic [1:0] addr0;
    logic rst1, in_v1, in_rdy1, out_rdy1, wr_en1, rd_en1, out_v1, sf_first1, sf_last1, nf_last1;
    logic [1:0] addr1;
    logic rst2, in_v2, in_rdy2, out_rdy2, wr_en2, rd_en2, out_v2, sf_first2, sf_last2, nf_last2;
    logic [0:0] addr2;

    mvau_inp_buf_ctrl #(.SF(4), .NF(3), .BUF_ADDR(2)) dut0 (
        .clk(clk), .rst(rst0), .in_v(in_v0), .in_rdy(in_rdy0), .out_rdy(out_rdy0),
        .wr_en(wr_en0), .rd_en(rd_en0), .addr(addr0), .out_v(out_v0),
        .sf_first(sf_first0), .sf_last(sf_last0), .nf_last(nf_last0)
    );
    mvau_inp_buf_ctrl #(.SF(4), .NF(1), .BUF_ADDR(2)) dut1 (
        .clk(clk), .rst(rst1), .in_v(in_v1), .in_rdy(in_rdy1), .out_rdy(out_rdy1),
        .wr_en(wr_en1), .rd_en(rd_en1), .addr(addr1), .out_v(out_v1),
        .sf_first(sf_first1), .sf_last(sf_last1), .nf_last(nf_last1)
    );
    mvau_inp_buf_ctrl #(.SF(1), .NF(2), .BUF_ADDR(1)) dut2 (
        .clk(clk), .rst(rst2), .in_v(in_v2), .in_rdy(in_rdy2), .out_rdy(out_rdy2),
        .wr_en(wr_en2), .rd_en(rd_en2), .addr(addr2), .out_v(out_v2),
        .sf_first(sf_first2), .sf_last(sf_last2), .nf_last(nf_last2)
    );

    logic [6:0] q0 [$];
    logic [6:0] q1 [$];
    logic [6:0] q2 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic beat_chk(input string nm, input logic [7:0] act, input int qsize, input logic [6:0] e);
        if (qsize == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected beat %0h with no expectation queued at %0t", nm, act, $time);
        end else begin
            chk(nm, {24'd0, act}, {24'd0, e[6], e});
        end
    endtask

    logic [6:0] e0, e1, e2;

    always @(negedge clk) begin
        if (!rst0 && out_v0 && out_rdy0) begin
            e0 = (q0.size() > 0) ? q0[0] : 7'd0;
            beat_chk("beat0", {in_rdy0, wr_en0, rd_en0, sf_first0, sf_last0, nf_last0, addr0}, q0.size(), e0);
            if (q0.size() > 0) void'(q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst1 && out_v1 && out_rdy1) begin
            e1 = (q1.size() > 0) ? q1[0] : 7'd0;
            beat_chk("beat1", {in_rdy1, wr_en1, rd_en1, sf_first1, sf_last1, nf_last1, addr1}, q1.size(), e1);
            if (q1.size() > 0) void'(q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst2 && out_v2 && out_rdy2) begin
            e2 = (q2.size() > 0) ? q2[0] : 7'd0;
            beat_chk("beat2", {in_rdy2, wr_en2, rd_en2, sf_first2, sf_last2, nf_last2, 1'b0, addr2}, q2.size(), e2);
            if (q2.size() > 0) void'(q2.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        in_v0 = 1'b1; out_rdy0 = 1'b1;
        in_v1 = 1'b1; out_rdy1 = 1'b1;
        in_v2 = 1'b1; out_rdy2 = 1'b1;

        // Outputs forced low while reset is held, even with handshakes asserted.
        @(negedge clk);
        chk("rst_outs0", {23'd0, in_rdy0, wr_en0, rd_en0, out_v0, sf_first0, sf_last0, nf_last0, addr0}, 32'd0);
        chk("rst_outs1", {23'd0, in_rdy1, wr_en1, rd_en1, out_v1, sf_first1, sf_last1, nf_last1, addr1}, 32'd0);
        chk("rst_outs2", {24'd0, in_rdy2, wr_en2, rd_en2, out_v2, sf_first2, sf_last2, nf_last2, addr2}, 32'd0);
        tick(2);
        in_v1 = 1'b0; out_rdy1 = 1'b0;
        in_v2 = 1'b0; out_rdy2 = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // Vector A: streaming with handshakes held high.
        foreach (V43[i]) q0.push_back(V43[i]);
        @(negedge clk);
        chk("first_cycle0", {29'd0, in_rdy0, addr0}, {29'd0, 1'b1, 2'd0});
        tick(12);

        // Vector B: two-cycle stalls at sf_cnt=2 in WRITE and in READ.
        foreach (V43[i]) q0.push_back(V43[i]);
        tick(2);
        out_rdy0 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_write", {28'd0, in_rdy0, wr_en0, out_v0, 1'b0, addr0}, {28'd0, 4'b0010, 2'd2} >> 0);
            tick(1);
        end
        out_rdy0 = 1'b1;
        tick(4);
        out_rdy0 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_read", {27'd0, in_rdy0, wr_en0, rd_en0, out_v0, 1'b0, addr0}, {27'd0, 5'b00110, 2'd2});
            tick(1);
        end
        out_rdy0 = 1'b1;
        tick(6);

        // Vector C: input bubbles at sf_cnt=1 in WRITE, then in_v low across READ passes.
        foreach (V43[i]) q0.push_back(V43[i]);
        tick(1);
        in_v0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bubble", {28'd0, out_v0, wr_en0, in_rdy0, 1'b0, addr0}, {28'd0, 4'b0010, 2'd1});
            tick(1);
        end
        in_v0 = 1'b1;
        tick(3);
        in_v0 = 1'b0;
        tick(8);
        in_v0 = 1'b1;

        // Vector D abandoned by reset at nf_cnt=1, sf_cnt=2.
        for (int i = 0; i < 6; i++) q0.push_back(V43[i]);
        tick(6);
        out_rdy0 = 1'b0;
        @(negedge clk);
        chk("pre_reset_read", {29'd0, rd_en0, addr0}, {29'd0, 1'b1, 2'd2});
        tick(1);
        rst0 = 1'b1; out_rdy0 = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {23'd0, in_rdy0, wr_en0, rd_en0, out_v0, sf_first0, sf_last0, nf_last0, addr0}, 32'd0);
        tick(1);
        rst0 = 1'b0;
        foreach (V43[i]) q0.push_back(V43[i]);
        @(negedge clk);
        chk("post_reset", {28'd0, in_rdy0, wr_en0, rd_en0, 1'b0, addr0}, {28'd0, 4'b1100, 2'd0});
        tick(12);
        in_v0 = 1'b0; out_rdy0 = 1'b0;

        // NF=1: continuous write-back, never replays.
        for (int v = 0; v < 2; v++) foreach (V41[i]) q1.push_back(V41[i]);
        in_v1 = 1'b1; out_rdy1 = 1'b1;
        tick(4);
        out_rdy1 = 1'b0;
        @(negedge clk);
        chk("nf1_stall", {28'd0, in_rdy1, rd_en1, nf_last1, 1'b0, addr1}, {28'd0, 4'b0010, 2'd0});
        tick(1);
        out_rdy1 = 1'b1;
        tick(4);
        in_v1 = 1'b0; out_rdy1 = 1'b0;
        @(negedge clk);
        chk("nf1_nflast_idle", {31'd0, nf_last1}, 32'd1);

        // SF=1: WRITE and READ alternate every beat.
        for (int v = 0; v < 3; v++) foreach (V12[i]) q2.push_back(V12[i]);
        in_v2 = 1'b1; out_rdy2 = 1'b1;
        tick(6);
        in_v2 = 1'b0; out_rdy2 = 1'b0;

        tick(2);
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);
        chk("drain2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvau_inp_buf_ctrl.md
# mvau_inp_buf_ctrl

Sequencing controller for the MVAU stream input buffer. For every input activation vector, it steps the buffer through one write pass and then NF−1 replay passes. In the write pass, SF words are captured from the input stream while being passed straight through. In each replay pass, the stored words are read back so the vector is reused against every neuron fold of the weight matrix. It sits between the input AXI-stream handshake and the buffer's wr_en/rd_en/addr pins, inside mvau_stream, and exposes fold-boundary flags to the accumulator logic.

## Interface
- SF, default 4: synapse folds per vector (MatrixW/SIMD); buffer depth used; must be ≥1.
- NF, default 3: neuron folds per vector (MatrixH/PE); must be ≥1.
- BUF_ADDR, default 2: buffer address width; 2**BUF_ADDR ≥ SF.
- clk, input, 1: main clock, rising edge.
- rst, input, 1: reset; one clock; reset is synchronous and active-high.
- in_v, input, 1: input stream word valid.
- in_rdy, output, 1: input stream ready (this block accepts a word).
- out_rdy, input, 1: downstream (compute/output) can take a beat this cycle.
- wr_en, output, 1: buffer write enable.
- rd_en, output, 1: buffer read select (1 = buffer contents, 0 = pass-through of input).
- addr, output, BUF_ADDR: buffer address (write and read).
- out_v, output, 1: buffer output word valid toward compute.
- sf_first, output, 1: current beat is synapse fold 0 (accumulator clear).
- sf_last, output, 1: current beat is synapse fold SF−1 (accumulator dump).
- nf_last, output, 1: current pass is neuron fold NF−1.

## Operation
- State: sf_cnt (0..SF−1), nf_cnt (0..NF−1), mode ∈ {WRITE, READ}.
- beat = out_v & out_rdy. Counters advance only on beat.
- WRITE (nf_cnt = 0):
  - in_rdy = out_rdy.
  - out_v = in_v.
  - wr_en = beat.
  - rd_en = 0.
  - addr = sf_cnt.
- READ (nf_cnt ≥ 1):
  - in_rdy = 0.
  - out_v = 1.
  - wr_en = 0.
  - rd_en = 1.
  - addr = sf_cnt.
- On beat with sf_cnt < SF−1: sf_cnt+1.
- On beat with sf_cnt = SF−1 (fold wrap): sf_cnt ← 0.
  - If nf_cnt < NF−1: nf_cnt+1, mode ← READ.
  - Else: nf_cnt ← 0, mode ← WRITE.
- NF = 1: mode never leaves WRITE; pure pass-through with write-back.
- SF = 1: every beat is a fold wrap; sf_first = sf_last = 1 on every beat.
- Flags (combinational):
  - sf_first = out_v & (sf_cnt = 0).
  - sf_last = out_v & (sf_cnt = SF−1).
  - nf_last = (nf_cnt = NF−1).
- No word is written twice per vector. Buffer contents are overwritten only in the next vector's WRITE pass.
- Stall: out_rdy = 0 freezes all state. In WRITE, in_rdy = 0 during a stall, so no input is consumed.
- in_v low in WRITE: out_v = 0, no beat, counters hold. READ passes never wait on in_v.

## Timing
- Zero-latency control: all outputs are combinational from state plus in_v/out_rdy. State updates on the rising clk edge.
- The buffer write of word k occurs on the same edge as the WRITE beat at sf_cnt = k. Word k is readable from the first READ cycle onward.
- Throughput: one beat per cycle with out_rdy held high. One vector takes SF·NF beats, SF of which consume input.
- Reset (rst high at an edge): sf_cnt = 0, nf_cnt = 0, mode = WRITE.
- While rst is high, all outputs are forced to 0: in_rdy, wr_en, rd_en, out_v, sf_first, sf_last, nf_last = 0 and addr = 0.
- First cycle after rst deasserts: WRITE, addr = 0.
- Reset mid-vector (any mode/count): the partial vector is abandoned. The next accepted input word is treated as word 0 of a new vector. Buffer contents are not cleared.
- Simultaneous fold wrap and last neuron fold: the mode returns to WRITE on the same edge. The next cycle can accept new input immediately, with no bubble.
- in_rdy never depends on in_v (no combinational loop on the input handshake). out_v depends on in_v only in WRITE.

## Test plan
- SF=4, NF=3, in_v and out_rdy held high, input words A0..A3 → cycles 0–3: wr_en = 1, addr 0,1,2,3, in_rdy = 1. Cycles 4–11: rd_en = 1, in_rdy = 0, addr repeats 0..3 twice. Cycle 12: WRITE resumes, accepting B0. sf_last on cycles 3, 7, 11; nf_last = 1 on cycles 8–11.
- Stall: toggle out_rdy low for 2 cycles at sf_cnt = 2 in both WRITE and READ → addr and counters hold. In WRITE, in_rdy = 0 and no extra write occurs. Total beats per vector still 12.
- Bubbles: in_v low for 3 cycles during WRITE at sf_cnt = 1 → out_v = 0, wr_en = 0, addr holds at 1, no advance. READ passes are unaffected by in_v.
- NF=1, SF=4 → rd_en never asserted. in_rdy tracks out_rdy. wr_en pulses at addr 0..3 continuously. nf_last is always 1.
- Reset mid-operation: assert rst during READ at nf_cnt = 1, sf_cnt = 2 → all outputs 0 while rst is high. After release: WRITE, addr = 0, and the next input word is written to address 0.
- SF=1, NF=2 → sf_first = sf_last = 1 on every beat. WRITE and READ alternate each beat, with addr = 0 throughout.
